// File: rtl/max_min_scan.sv
// Streams a window of words from a read-latency-RD_LAT memory and reports the
// largest and smallest values, with the first offset at which each occurs.
module max_min_scan #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [AW-1:0]    i_base,
  input  logic [LW-1:0]    i_len,
  input  logic             i_signed,
  output logic             o_rden,
  output logic [AW-1:0]    o_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_max,
  output logic [WIDTH-1:0] o_min,
  output logic [AW-1:0]    o_max_idx,
  output logic [AW-1:0]    o_min_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Valid pipeline pattern once only the final read is still in flight.
  localparam logic [RD_LAT-1:0] LAST_ONLY = RD_LAT'(1) << (RD_LAT - 1);

  state_t             r_state;
  logic [AW-1:0]      r_addr;
  logic [LW-1:0]      r_cnt;
  logic               r_sgn;
  logic [RD_LAT-1:0]  r_vld;
  logic               r_first;
  logic [AW-1:0]      r_idx;
  logic               r_err;
  logic [WIDTH-1:0]   r_max;
  logic [WIDTH-1:0]   r_min;
  logic [AW-1:0]      r_max_idx;
  logic [AW-1:0]      r_min_idx;

  logic w_rden;
  logic w_take;
  logic w_len_bad;
  logic w_gt;
  logic w_lt;

  assign w_rden    = (r_state == S_RUN);
  assign w_take    = r_vld[RD_LAT-1];
  assign w_len_bad = (i_len == '0) || (i_len > LW'(DEPTH));
  assign w_gt      = r_sgn ? ($signed(i_data) > $signed(r_max)) : (i_data > r_max);
  assign w_lt      = r_sgn ? ($signed(i_data) < $signed(r_min)) : (i_data < r_min);

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values within the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_sgn     <= 1'b0;
      r_vld     <= '0;
      r_first   <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_max     <= '0;
      r_min     <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
    end else begin
      r_vld <= (r_vld << 1) | RD_LAT'(w_rden);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr  <= i_base;
            r_cnt   <= i_len;
            r_sgn   <= i_signed;
            r_err   <= w_len_bad;
            r_first <= 1'b1;
            r_idx   <= '0;
            r_state <= w_len_bad ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_addr <= r_addr + AW'(1);
          r_cnt  <= r_cnt - LW'(1);
          if (r_cnt == LW'(1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_vld == LAST_ONLY) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase

      // The first sample seeds both extremes; later ones replace only on strict wins.
      if (w_take) begin
        r_idx   <= r_idx + AW'(1);
        r_first <= 1'b0;
        if (r_first) begin
          r_max     <= i_data;
          r_min     <= i_data;
          r_max_idx <= '0;
          r_min_idx <= '0;
        end else begin
          if (w_gt) begin
            r_max     <= i_data;
            r_max_idx <= r_idx;
          end
          if (w_lt) begin
            r_min     <= i_data;
            r_min_idx <= r_idx;
          end
        end
      end
    end
  end

  assign o_rden    = w_rden;
  assign o_addr    = r_addr;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_err     = r_err;
  assign o_max     = r_max;
  assign o_min     = r_min;
  assign o_max_idx = r_max_idx;
  assign o_min_idx = r_min_idx;

endmodule

// File: tb/tb_max_min_scan.sv
// Directed bench: two scanners (read latency 1 and 3) fed by small behavioural
// memories, with hand-computed expectations checked by immediate assertions.
module tb_max_min_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic       start1, sgn1, rden1, busy1, done1, err1;
  logic [6:0] base1, addr1, maxi1, mini1;
  logic [7:0] len1;
  logic [7:0] data1, max1, min1;
  logic [7:0] mem1 [128];

  // Latency-3 instance
  logic       start3, sgn3, rden3, busy3, done3, err3;
  logic [6:0] base3, addr3, maxi3, mini3;
  logic [7:0] len3;
  logic [7:0] data3, max3, min3;
  logic [7:0] mem3 [128];
  logic [7:0] p3 [3];

  max_min_scan #(.DEPTH(128), .WIDTH(8), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_base(base1), .i_len(len1),
    .i_signed(sgn1), .o_rden(rden1), .o_addr(addr1), .i_data(data1),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_max(max1), .o_min(min1),
    .o_max_idx(maxi1), .o_min_idx(mini1)
  );

  max_min_scan #(.DEPTH(128), .WIDTH(8), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_base(base3), .i_len(len3),
    .i_signed(sgn3), .o_rden(rden3), .o_addr(addr3), .i_data(data3),
    .o_busy(busy3), .o_done(done3), .o_err(err3), .o_max(max3), .o_min(min3),
    .o_max_idx(maxi3), .o_min_idx(mini3)
  );

  // Memories return junk whenever no read was issued, so untagged sampling shows up.
  always @(posedge clk) data1 <= rden1 ? mem1[addr1] : 8'hA5;
  always @(posedge clk) begin
    p3[0] <= rden3 ? mem3[addr3] : 8'hA5;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign data3 = p3[2];

  int total = 0;
  int bad   = 0;
  int addr_log [16];
  int nlog;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a scan on the latency-1 instance and runs it to o_done (or a timeout).
  task automatic run1(input logic [6:0] base, input logic [7:0] len, input logic sgn,
                      input bit disturb, output int done_cyc, output int nrd, output int first_rd);
    done_cyc = -1;
    nrd      = 0;
    first_rd = -1;
    nlog     = 0;
    @(negedge clk);
    start1 = 1'b1; base1 = base; len1 = len; sgn1 = sgn;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) start1 = 1'b0;
      if (disturb && n == 2) begin
        start1 = 1'b1; base1 = 7'd50; len1 = 8'd2; sgn1 = ~sgn;
      end
      if (disturb && n == 3) start1 = 1'b0;
      if (rden1) begin
        if (first_rd < 0) first_rd = n;
        if (nlog < 16) addr_log[nlog] = int'(addr1);
        nlog++;
        nrd++;
      end
      if (done1) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  initial begin
    int dc, nr, fr, d1, d2, busy_at7;

    rst = 1'b1;
    start1 = 0; base1 = 0; len1 = 0; sgn1 = 0;
    start3 = 0; base3 = 0; len3 = 0; sgn3 = 0;
    foreach (mem1[i]) mem1[i] = 8'h33;
    mem1[0] = 8'd5; mem1[1] = 8'hFD; mem1[2] = 8'd7; mem1[3] = 8'hFD;
    mem1[126] = 8'h10; mem1[127] = 8'h20;
    foreach (mem3[i]) mem3[i] = 8'h80;
    mem3[50] = 8'h7F;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_err",  32'(err1),  0);
    check("rst_rden", 32'(rden1), 0);
    check("rst_max",  32'(max1),  0);
    check("rst_mini", 32'(mini1), 0);
    rst = 1'b0;

    // Signed scan; a start and an i_signed flip mid-scan must both be ignored.
    run1(7'd0, 8'd4, 1'b1, 1'b1, dc, nr, fr);
    check("s_done_cyc", 32'(dc), 6);
    check("s_nrd",      32'(nr), 4);
    check("s_err",      32'(err1), 0);
    check("s_max",      32'(max1), 32'h07);
    check("s_max_idx",  32'(maxi1), 2);
    check("s_min",      32'(min1), 32'hFD);
    check("s_min_idx",  32'(mini1), 1);
    repeat (3) @(negedge clk);
    check("s_hold_max", 32'(max1), 32'h07);
    check("s_hold_min", 32'(min1), 32'hFD);

    // Same data compared unsigned.
    run1(7'd0, 8'd4, 1'b0, 1'b0, dc, nr, fr);
    check("u_done_cyc", 32'(dc), 6);
    check("u_max",      32'(max1), 32'hFD);
    check("u_max_idx",  32'(maxi1), 1);
    check("u_min",      32'(min1), 32'h05);
    check("u_min_idx",  32'(mini1), 0);

    // Window wrapping past the top of memory: 0x10,0x20,0x05,0xFD unsigned.
    run1(7'd126, 8'd4, 1'b0, 1'b0, dc, nr, fr);
    check("w_first_rd", 32'(fr), 1);
    check("w_nrd",      32'(nr), 4);
    check("w_addr0",    32'(addr_log[0]), 126);
    check("w_addr1",    32'(addr_log[1]), 127);
    check("w_addr2",    32'(addr_log[2]), 0);
    check("w_addr3",    32'(addr_log[3]), 1);
    check("w_max",      32'(max1), 32'hFD);
    check("w_max_idx",  32'(maxi1), 3);
    check("w_min",      32'(min1), 32'h05);
    check("w_min_idx",  32'(mini1), 2);

    // Zero length: immediate done, error flag, no reads, results untouched.
    run1(7'd3, 8'd0, 1'b1, 1'b0, dc, nr, fr);
    check("z_done_cyc", 32'(dc), 1);
    check("z_err",      32'(err1), 1);
    check("z_nrd",      32'(nr), 0);
    check("z_max",      32'(max1), 32'hFD);
    check("z_min_idx",  32'(mini1), 2);
    @(negedge clk);
    check("z_err_held", 32'(err1), 1);

    // Oversized length is also an error.
    run1(7'd0, 8'd129, 1'b1, 1'b0, dc, nr, fr);
    check("o_err",      32'(err1), 1);
    check("o_nrd",      32'(nr), 0);

    // Exactly DEPTH words is legal and clears the error.
    run1(7'd0, 8'd128, 1'b0, 1'b0, dc, nr, fr);
    check("f_done_cyc", 32'(dc), 130);
    check("f_err",      32'(err1), 0);
    check("f_nrd",      32'(nr), 128);

    // Back-to-back: start held high is re-accepted in the IDLE cycle after DONE.
    @(negedge clk);
    start1 = 1'b1; base1 = 7'd0; len1 = 8'd4; sgn1 = 1'b1;
    d1 = -1; d2 = -1; busy_at7 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 7) busy_at7 = int'(busy1);
      if (n == 8) start1 = 1'b0;
      if (done1 && d1 < 0) d1 = n;
      else if (done1 && d2 < 0) begin
        d2 = n;
        break;
      end
    end
    check("b_done1",   32'(d1), 6);
    check("b_idle",    32'(busy_at7), 0);
    check("b_done2",   32'(d2), 13);
    check("b_max",     32'(max1), 32'h07);

    // Latency-3 instance, full-memory scan.
    @(negedge clk);
    start3 = 1'b1; base3 = 7'd0; len3 = 8'd128; sgn3 = 1'b1;
    dc = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) start3 = 1'b0;
      if (done3) begin
        dc = n;
        break;
      end
    end
    check("l3_done_cyc", 32'(dc), 132);
    check("l3_max",      32'(max3), 32'h7F);
    check("l3_max_idx",  32'(maxi3), 50);
    check("l3_min",      32'(min3), 32'h80);
    check("l3_min_idx",  32'(mini3), 0);

    // Reset pulsed during RUN aborts with no done pulse.
    @(negedge clk);
    start1 = 1'b1; base1 = 7'd0; len1 = 8'd4; sgn1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("r_running", 32'(rden1), 1);
    rst = 1'b1;
    @(negedge clk);
    check("r_busy",    32'(busy1), 0);
    check("r_max",     32'(max1), 0);
    check("r_min",     32'(min1), 0);
    rst = 1'b0;
    dc = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done1 || busy1) dc++;
    end
    check("r_quiet",   32'(dc), 0);
    check("r_max_late", 32'(max1), 0);

    run1(7'd0, 8'd4, 1'b1, 1'b0, dc, nr, fr);
    check("r2_done_cyc", 32'(dc), 6);
    check("r2_max",      32'(max1), 32'h07);
    check("r2_min_idx",  32'(mini1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
